// File: rtl/fpu_req_dispatch_pkg.sv
// Shared types and defaults for the FPU request dispatcher.
// Holds the dispatch FSM states, default widths and the credit counter width helper.
package fpu_interco_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEL      = 2'd1,
    WAIT_GNT = 2'd2
  } dispatch_state_e;

  localparam int unsigned DEF_NB_APUS         = 16;
  localparam int unsigned DEF_NB_ARGS         = 3;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_OP_WIDTH        = 6;
  localparam int unsigned DEF_FLAG_WIDTH      = 15;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;

  // The counter must be able to represent MAX_OUTSTANDING itself.
  function automatic int unsigned credit_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fpu_req_dispatch_if.sv
// Request bus between initiator, dispatcher and FPU units.
// The slave modport is the dispatcher's view; master is the surrounding environment.
interface fpu_req_dispatch_if
  import fpu_interco_pkg::*;
#(
  parameter int unsigned NB_APUS    = DEF_NB_APUS,
  parameter int unsigned NB_ARGS    = DEF_NB_ARGS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = DEF_OP_WIDTH,
  parameter int unsigned FLAG_WIDTH = DEF_FLAG_WIDTH
);

  logic                          req_i;
  logic                          gnt_o;
  logic [NB_ARGS*DATA_WIDTH-1:0] operands_i;
  logic [OP_WIDTH-1:0]           op_i;
  logic [FLAG_WIDTH-1:0]         flags_i;
  logic [NB_APUS-1:0]            apu_req_o;
  logic [NB_APUS-1:0]            apu_gnt_i;
  logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o;
  logic [OP_WIDTH-1:0]           apu_op_o;
  logic [FLAG_WIDTH-1:0]         apu_flags_o;
  logic [NB_APUS-1:0]            apu_rvalid_i;

  modport slave (
    input  req_i, operands_i, op_i, flags_i, apu_gnt_i, apu_rvalid_i,
    output gnt_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );

  modport master (
    output req_i, operands_i, op_i, flags_i, apu_gnt_i, apu_rvalid_i,
    input  gnt_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );

endinterface

// File: rtl/fpu_req_dispatch_rr_pick.sv
// Combinational round-robin picker: first set bit of i_elig at or after i_ptr.
// N must be a power of two so the index wraps naturally.
module fpu_rr_pick #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]         i_elig,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_onehot,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);

  localparam int unsigned IW = $clog2(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;

  assign w_dbl = {i_elig, i_elig} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[IW-1:0];
    end
  end

  assign o_valid  = |i_elig;
  assign o_idx    = i_ptr + w_off;
  assign o_onehot = o_valid ? ({{(N-1){1'b0}}, 1'b1} << o_idx) : '0;

endmodule

// File: rtl/fpu_req_dispatch.sv
// Single-slot request dispatcher to NB_APUS FPU units, round-robin over units with free credit.
// Optional perf counters are built when FPU_DISPATCH_PERF_CNT_EN is defined.
module fpu_req_dispatch
  import fpu_interco_pkg::*;
#(
  parameter int unsigned NB_APUS         = DEF_NB_APUS,
  parameter int unsigned NB_ARGS         = DEF_NB_ARGS,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned OP_WIDTH        = DEF_OP_WIDTH,
  parameter int unsigned FLAG_WIDTH      = DEF_FLAG_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_req_dispatch_if.slave   bus,
  output logic                busy_o,
  output logic                err_o,
  output logic [31:0]         perf_dispatch_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
);

  localparam int unsigned PW = $clog2(NB_APUS);
  localparam int unsigned CW = credit_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_CRED = CW'(MAX_OUTSTANDING);

  dispatch_state_e               r_state;
  logic                          r_slot_valid;
  logic [NB_ARGS*DATA_WIDTH-1:0] r_operands;
  logic [OP_WIDTH-1:0]           r_op;
  logic [FLAG_WIDTH-1:0]         r_flags;
  logic [PW-1:0]                 r_target;
  logic [PW-1:0]                 r_rr_ptr;
  logic                          r_err;

  logic [NB_APUS-1:0] w_elig;
  logic [NB_APUS-1:0] w_credit_nz;
  logic [NB_APUS-1:0] w_underflow;
  logic [NB_APUS-1:0] w_pick_oh;
  logic [PW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic [NB_APUS-1:0] w_apu_req;
  logic [NB_APUS-1:0] w_inc;
  logic [PW-1:0]      w_hs_idx;
  logic               w_hs;
  logic               w_gnt;
  logic               w_capture;

  fpu_rr_pick #(.N(NB_APUS)) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Per-unit credit counters; simultaneous dispatch and response cancel out.
  for (genvar gi = 0; gi < NB_APUS; gi++) begin : g_credit
    logic [CW-1:0] r_cnt;

    assign w_inc[gi]       = w_apu_req[gi] & bus.apu_gnt_i[gi];
    assign w_elig[gi]      = (r_cnt < MAX_CRED);
    assign w_credit_nz[gi] = (r_cnt != '0);
    assign w_underflow[gi] = bus.apu_rvalid_i[gi] & ~w_inc[gi] & (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc[gi] && !bus.apu_rvalid_i[gi]) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_inc[gi] && bus.apu_rvalid_i[gi] && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_apu_req = '0;
    case (r_state)
      SEL:      w_apu_req = w_pick_oh;
      WAIT_GNT: w_apu_req = {{(NB_APUS-1){1'b0}}, 1'b1} << r_target;
      default:  w_apu_req = '0;
    endcase
  end

  assign w_hs      = |(w_apu_req & bus.apu_gnt_i);
  assign w_hs_idx  = (r_state == WAIT_GNT) ? r_target : w_pick_idx;
  assign w_gnt     = ~r_slot_valid | w_hs;
  assign w_capture = bus.req_i & w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_slot_valid <= 1'b0;
      r_operands   <= '0;
      r_op         <= '0;
      r_flags      <= '0;
      r_target     <= '0;
      r_rr_ptr     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= r_err | (|w_underflow);
      if (w_capture) begin
        r_operands <= bus.operands_i;
        r_op       <= bus.op_i;
        r_flags    <= bus.flags_i;
      end
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_slot_valid <= 1'b1;
            r_state      <= SEL;
          end
        end
        SEL, WAIT_GNT: begin
          if (w_hs) begin
            r_rr_ptr     <= w_hs_idx + 1'b1;
            r_slot_valid <= w_capture;
            r_state      <= w_capture ? SEL : IDLE;
          end else if ((r_state == SEL) && w_pick_valid) begin
            // Once a unit has seen the request it keeps it until granted.
            r_target <= w_pick_idx;
            r_state  <= WAIT_GNT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o          = w_gnt;
  assign bus.apu_req_o      = w_apu_req;
  assign bus.apu_operands_o = r_operands;
  assign bus.apu_op_o       = r_op;
  assign bus.apu_flags_o    = r_flags;
  assign busy_o             = r_slot_valid | (|w_credit_nz);
  assign err_o              = r_err;

`ifdef FPU_DISPATCH_PERF_CNT_EN
  logic [31:0] r_perf_disp;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_disp  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_hs) r_perf_disp <= r_perf_disp + 32'd1;
      if (r_slot_valid && !w_hs) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_dispatch_cnt_o = r_perf_disp;
  assign perf_stall_cnt_o    = r_perf_stall;
`else
  assign perf_dispatch_cnt_o = 32'd0;
  assign perf_stall_cnt_o    = 32'd0;
`endif

endmodule
